// File: rtl/dram_cmd_sequencer_pkg.sv
// Shared timing constants, command/state encodings and the address decode
// for the DDR5 command sequencer.
package dram_cmd_sequencer_pkg;

    localparam int ADDR_WIDTH = 36;

    // DIMM timing, in command-clock cycles
    localparam int TRCD   = 39;
    localparam int TCAS   = 40;
    localparam int TCWL   = 38;
    localparam int TBURST = 8;
    localparam int TWR    = 72;
    localparam int TRP    = 39;

    typedef enum logic [2:0] {
        CMD_ACT0 = 3'd0,
        CMD_ACT1 = 3'd1,
        CMD_RD0  = 3'd2,
        CMD_RD1  = 3'd3,
        CMD_WR0  = 3'd4,
        CMD_WR1  = 3'd5,
        CMD_PRE  = 3'd6
    } dram_cmd_e;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_IFETCH  = 2'd2,
        OP_ILLEGAL = 2'd3
    } req_op_e;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ACT0      = 4'd1,
        S_ACT1      = 4'd2,
        S_WAIT_RCD  = 4'd3,
        S_CAS0      = 4'd4,
        S_CAS1      = 4'd5,
        S_WAIT_DATA = 4'd6,
        S_PRE       = 4'd7,
        S_WAIT_RP   = 4'd8
    } seq_state_e;

    typedef struct packed {
        logic        ch;
        logic [2:0]  bg;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } dram_addr_t;

    // Split a physical address into DIMM coordinates
    function automatic dram_addr_t decode_addr(input logic [ADDR_WIDTH-1:0] addr);
        dram_addr_t d;
        d.ch   = addr[6];
        d.bg   = addr[9:7];
        d.bank = addr[11:10];
        d.row  = addr[33:18];
        d.col  = {addr[17:12], addr[5:2]};
        return d;
    endfunction

    // Flat bank index {ch, bg, bank} used by the open-row table
    function automatic logic [5:0] bank_index(input dram_addr_t d);
        return {d.ch, d.bg, d.bank};
    endfunction

endpackage

// File: rtl/dram_cmd_sequencer_open_row_table.sv
// Per-bank open-row tracker (64 banks indexed by {ch, bg, bank}).
// Only instantiated when OPEN_PAGE_EN is defined.
module dram_open_row_table (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  lookup_idx,
    input  logic [15:0] lookup_row,
    output logic        lookup_hit,
    output logic        lookup_miss,
    output logic        lookup_empty,
    input  logic        set_en,
    input  logic [5:0]  set_idx,
    input  logic [15:0] set_row,
    input  logic        clr_en,
    input  logic [5:0]  clr_idx
);

    logic [63:0] valid_q;
    logic [15:0] row_q [64];

    // Valid bits: set when a row is activated, cleared on precharge or reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (set_en) valid_q[set_idx] <= 1'b1;
            if (clr_en) valid_q[clr_idx] <= 1'b0;
        end
    end

    // Row storage needs no reset; it is qualified by the valid bit
    always_ff @(posedge clk) begin
        if (set_en) row_q[set_idx] <= set_row;
    end

    // Classify the incoming request against the bank's open row
    always_comb begin
        lookup_empty = !valid_q[lookup_idx];
        lookup_hit   = valid_q[lookup_idx] && (row_q[lookup_idx] == lookup_row);
        lookup_miss  = valid_q[lookup_idx] && (row_q[lookup_idx] != lookup_row);
    end

endmodule

// File: rtl/dram_cmd_sequencer.sv
// DDR5 command sequencer: accepts one request at a time and issues
// ACT -> RD/WR -> PRE with tRCD/tCAS/tCWL/tBURST/tWR/tRP spacing.
// Optional feature macro: OPEN_PAGE_EN (open-page policy with row table).
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_op/req_addr must stay stable until then.
module dram_cmd_sequencer
    import dram_cmd_sequencer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_WIDTH,
    parameter int T_RCD   = TRCD,
    parameter int T_CAS   = TCAS,
    parameter int T_CWL   = TCWL,
    parameter int T_BURST = TBURST,
    parameter int T_WR    = TWR,
    parameter int T_RP    = TRP,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              cmd_valid,
    output logic [2:0]        cmd_type,
    output logic              cmd_channel,
    output logic [2:0]        cmd_bg,
    output logic [1:0]        cmd_bank,
    output logic [15:0]       cmd_row,
    output logic [9:0]        cmd_col,
    output logic              done_pulse,
    output logic              err_illegal_op,
    output logic [3:0]        dbg_state
);

    if ((T_CWL + T_BURST + T_WR >= 2**CNT_W) || (T_CAS + T_BURST >= 2**CNT_W) ||
        (T_RCD < 2) || (T_RP < 2) || (ADDR_W != ADDR_WIDTH)) begin : g_bad_cfg
        $error("dram_cmd_sequencer: timing does not fit the wait counter or address width mismatch");
    end

    // A command occupies the cycle at each end of a wait, so each WAIT_*
    // state lasts (delay-1) cycles; the down-counter runs (delay-1)-1 .. 0.
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(T_CAS + T_BURST - 2);
    localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_CWL + T_BURST + T_WR - 2);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 2);

    seq_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             is_write;
    dram_addr_t       cur;
    dram_addr_t       req_dec;

    assign req_dec     = decode_addr(req_addr);
    assign cmd_channel = cur.ch;
    assign cmd_bg      = cur.bg;
    assign cmd_bank    = cur.bank;
    assign cmd_row     = cur.row;
    assign cmd_col     = cur.col;
    assign dbg_state   = state;

`ifdef OPEN_PAGE_EN
    logic lk_hit;
    logic lk_miss;
    logic lk_empty;

    dram_open_row_table u_row_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_idx   (bank_index(req_dec)),
        .lookup_row   (req_dec.row),
        .lookup_hit   (lk_hit),
        .lookup_miss  (lk_miss),
        .lookup_empty (lk_empty),
        .set_en       (state == S_ACT1),
        .set_idx      (bank_index(cur)),
        .set_row      (cur.row),
        .clr_en       (state == S_PRE),
        .clr_idx      (bank_index(cur))
    );
`endif

    // Sequencer FSM with registered command/handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            is_write       <= 1'b0;
            cur            <= '0;
            req_ready      <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_type       <= CMD_ACT0;
            done_pulse     <= 1'b0;
            err_illegal_op <= 1'b0;
        end else begin
            cmd_valid      <= 1'b0;
            done_pulse     <= 1'b0;
            err_illegal_op <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        if (req_op == OP_ILLEGAL) begin
                            err_illegal_op <= 1'b1;
                        end else begin
                            req_ready <= 1'b0;
                            cur       <= req_dec;
                            is_write  <= (req_op == OP_WRITE);
                            cmd_valid <= 1'b1;
`ifdef OPEN_PAGE_EN
                            if (lk_hit) begin
                                state    <= S_CAS0;
                                cmd_type <= (req_op == OP_WRITE) ? CMD_WR0 : CMD_RD0;
                            end else if (lk_miss) begin
                                state    <= S_PRE;
                                cmd_type <= CMD_PRE;
                            end else begin
                                state    <= S_ACT0;
                                cmd_type <= CMD_ACT0;
                            end
`else
                            state    <= S_ACT0;
                            cmd_type <= CMD_ACT0;
`endif
                        end
                    end
                end
                S_ACT0: begin
                    state     <= S_ACT1;
                    cmd_valid <= 1'b1;
                    cmd_type  <= CMD_ACT1;
                end
                S_ACT1: begin
                    state <= S_WAIT_RCD;
                    cnt   <= LD_RCD;
                end
                S_WAIT_RCD: begin
                    if (cnt == '0) begin
                        state     <= S_CAS0;
                        cmd_valid <= 1'b1;
                        cmd_type  <= is_write ? CMD_WR0 : CMD_RD0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CAS0: begin
                    state     <= S_CAS1;
                    cmd_valid <= 1'b1;
                    cmd_type  <= is_write ? CMD_WR1 : CMD_RD1;
                end
                S_CAS1: begin
                    state <= S_WAIT_DATA;
                    cnt   <= is_write ? LD_WR : LD_RD;
                end
                S_WAIT_DATA: begin
                    if (cnt == '0) begin
`ifdef OPEN_PAGE_EN
                        // Row stays open for the next request to this bank
                        state      <= S_IDLE;
                        req_ready  <= 1'b1;
                        done_pulse <= 1'b1;
`else
                        state      <= S_PRE;
                        cmd_valid  <= 1'b1;
                        cmd_type   <= CMD_PRE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PRE: begin
                    state <= S_WAIT_RP;
                    cnt   <= LD_RP;
                end
                S_WAIT_RP: begin
                    if (cnt == '0) begin
`ifdef OPEN_PAGE_EN
                        // Only a row miss precharges; it continues into ACT
                        state      <= S_ACT0;
                        cmd_valid  <= 1'b1;
                        cmd_type   <= CMD_ACT0;
`else
                        state      <= S_IDLE;
                        req_ready  <= 1'b1;
                        done_pulse <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
